apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before abort; used only with APB_TIMEOUT_EN.
REQ-004 SHALL have port pclk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port preset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  2  per-requester transfer request; bit i = requester i.
REQ-007 SHALL have port req_write  in  2  per-requester direction; 1 = write.
REQ-008 SHALL have port req_addr  in  2*ADDR_W  per-requester address; requester i in slice [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata  in  2*DATA_W  per-requester write data; same slicing as req_addr.
REQ-010 SHALL have port rsp_done  out  2  one-cycle completion strobe to requester i.
REQ-011 SHALL have port rsp_rdata  out  DATA_W  read data; valid only while any rsp_done bit is high.
REQ-012 SHALL have port rsp_err  out  1  error flag; valid only while any rsp_done bit is high.
REQ-013 SHALL have port busy  out  1  high in SETUP and ACCESS.
REQ-014 SHALL have ports psel, penable, pwrite  out  1 each  APB master controls.
REQ-015 SHALL have ports paddr  out  ADDR_W, and pwdata  out  DATA_W  APB master address/data.
REQ-016 SHALL have ports prdata  in  DATA_W, pready  in  1, and pslverr  in  1  APB slave responses.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-018 SHALL, in IDLE with any req_valid high, grant one requester and move to SETUP next cycle.
REQ-019 SHALL, in IDLE with no req_valid high, stay in IDLE.
REQ-020 SHALL arbitrate round-robin: if both requesters are valid, grant the one not granted last; a sole requester always wins.
REQ-021 SHALL latch the granted requester's addr, wdata and write into paddr, pwdata and pwrite on the IDLE->SETUP edge, held stable until the next grant.
REQ-022 SHALL drive psel=1 and penable=0 in SETUP for exactly one cycle, then enter ACCESS.
REQ-023 SHALL drive psel=1 and penable=1 in ACCESS until pready=1 is sampled.
REQ-024 SHALL, in an ACCESS cycle with pready=1, combinationally assert rsp_done[grant], with rsp_rdata=prdata (0 for writes) and rsp_err=pslverr, then return to IDLE.
REQ-025 SHALL give minimum latency from request seen in IDLE (cycle N) to rsp_done of cycle N+2, i.e. 3 cycles per transfer.
REQ-026 SHALL drive psel=0, penable=0, rsp_done=0, rsp_rdata=0 and rsp_err=0 in IDLE.
REQ-027 SHALL sample req_* only in IDLE; a requester holds req_valid until its rsp_done; changes after grant are ignored.
REQ-028 SHALL treat a requester re-asserting req_valid the cycle after its rsp_done as a new request, subject to round-robin.

Reset
REQ-029 SHALL, on preset=1, immediately force state to IDLE, psel/penable/pwrite to 0, paddr/pwdata to 0, rsp_* to 0 and busy to 0.
REQ-030 SHALL set the round-robin pointer so that requester 0 wins the first contention after reset.
REQ-031 SHALL abandon a transfer if reset is asserted mid-transfer, with no rsp_done issued for it.

Configuration
REQ-032 SHALL, with APB_TIMEOUT_EN defined, count ACCESS cycles with pready=0, and on the TIMEOUT_CYC-th such cycle assert rsp_done[grant] with rsp_err=1 and rsp_rdata=0, then go to IDLE.
REQ-033 SHALL reset the timeout counter to 0 on preset and on every entry to ACCESS.
REQ-034 SHALL, without APB_TIMEOUT_EN, contain no timeout counter and wait in ACCESS indefinitely for pready.

Verification
REQ-035 SHALL cover: req0 write addr 0x04 data 0xA5A5A5A5, pready=1 -> SETUP, 1-cycle ACCESS, rsp_done=2'b01, rsp_err=0.
REQ-036 SHALL cover: read-back of 0x04 by req1 -> rsp_done=2'b10, rsp_rdata=0xA5A5A5A5.
REQ-037 SHALL cover: both valid after reset, each issuing 4 transfers -> grant order 0,1,0,1,..., with no requester granted twice in a row.
REQ-038 SHALL cover: pready held low 3 ACCESS cycles then pslverr=1 with pready -> psel/penable stay high 4 cycles, paddr stable, rsp_err=1.
REQ-039 SHALL cover: APB_TIMEOUT_EN with TIMEOUT_CYC=16 and pready stuck 0 -> rsp_done after 16 ACCESS cycles with rsp_err=1; without the macro, still in ACCESS at 100 cycles.
REQ-040 SHALL cover: preset pulsed during ACCESS -> psel=0 and busy=0 immediately, with no rsp_done.

Source files
------------

// File: rtl/apb_master_arb.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_done,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  generate
    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("apb_master_arb: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                win;
  logic                timeout;

  // last_q is the most recent winner; requester 1 wins only if it is alone
  // or requester 0 won last time.
  assign win = req_valid[1] & (~req_valid[0] | ~last_q);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign timeout = (state_q == S_ACCESS) && !pready &&
                   (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rsp_done  = 2'b00;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d  = S_SETUP;
          grant_d  = win;
          last_d   = win;
          pwrite_d = win ? req_write[1] : req_write[0];
          paddr_d  = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_d = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (pready || timeout) begin
          state_d   = S_IDLE;
          rsp_done  = grant_q ? 2'b10 : 2'b01;
          rsp_err   = pready ? pslverr : 1'b1;
          rsp_rdata = (pready && !pwrite_q) ? prdata : '0;
        end else begin
`ifdef APB_TIMEOUT_EN
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign psel    = (state_q != S_IDLE);
  assign penable = (state_q == S_ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: vector table, scoreboard of
// expected completions, and hand-written timeout / reset / round-robin sequences.
module tb_apb_master_arb;

  logic        pclk = 1'b0;
  logic        preset;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  logic [31:0] mem [0:255];

  typedef struct {
    int          rid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_chk = 0;
  int   n_fail = 0;

  apb_master_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Simple memory-backed APB slave
  assign prdata = mem[paddr[9:2]];
  always @(posedge pclk)
    if (psel && penable && pready && pwrite) mem[paddr[9:2]] <= pwdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every completion strobe must match the oldest outstanding expectation
  always @(negedge pclk) begin
    if (rsp_done != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(rsp_done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_done", 64'(rsp_done), 64'(e.done));
        check("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("sb_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Entered and left at posedge+1 with the DUT in IDLE
  task automatic run_vec(input vec_t v);
    logic [1:0] mask;
    mask = (v.rid == 1) ? 2'b10 : 2'b01;
    sb.push_back('{mask, v.exp_rdata, v.exp_err});
    req_valid[v.rid]          = 1'b1;
    req_write[v.rid]          = v.wr;
    req_addr[v.rid*32 +: 32]  = v.addr;
    req_wdata[v.rid*32 +: 32] = v.wdata;
    pslverr                   = v.slverr;
    check("idle_busy", 64'(busy), 64'd0);
    @(posedge pclk); #1;
    check("setup_psel_pen", 64'({psel, penable}), 64'(2'b10));
    check("setup_paddr", 64'(paddr), 64'(v.addr));
    check("setup_pwrite", 64'(pwrite), 64'(v.wr));
    if (v.wr) check("setup_pwdata", 64'(pwdata), 64'(v.wdata));
    check("setup_no_done", 64'(rsp_done), 64'd0);
    @(posedge pclk); #1;
    for (int k = 0; k < v.waits; k++) begin
      check("wait_psel_pen", 64'({psel, penable}), 64'(2'b11));
      check("wait_paddr", 64'(paddr), 64'(v.addr));
      check("wait_no_done", 64'(rsp_done), 64'd0);
      @(posedge pclk); #1;
    end
    check("access_psel_pen", 64'({psel, penable}), 64'(2'b11));
    pready = 1'b1;
    #1;
    check("access_done", 64'(rsp_done), 64'(mask));
    @(posedge pclk); #1;
    pready    = 1'b0;
    pslverr   = 1'b0;
    req_valid = 2'b00;
    check("back_idle", 64'({psel, penable, busy}), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, 32'h04, 32'hA5A5A5A5, 0, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{1, 1'b0, 32'h04, 32'h0,        0, 1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[2] = '{1, 1'b1, 32'h08, 32'h12345678, 1, 1'b0, 32'h0,        1'b0};
    vecs[3] = '{0, 1'b0, 32'h08, 32'h0,        2, 1'b0, 32'h12345678, 1'b0};
    vecs[4] = '{0, 1'b1, 32'h0C, 32'hDEADBEEF, 3, 1'b1, 32'h0,        1'b1};
    vecs[5] = '{1, 1'b0, 32'h10, 32'h0,        0, 1'b0, 32'h0,        1'b0};
    vecs[6] = '{0, 1'b0, 32'h04, 32'h0,        0, 1'b1, 32'hA5A5A5A5, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    preset = 1'b1; req_valid = 2'b00; req_write = 2'b00;
    req_addr = '0; req_wdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_ctrl", 64'({psel, penable, pwrite, busy}), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rsp", 64'({rsp_done, rsp_err, rsp_rdata}), 64'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stalled ACCESS with pready stuck low
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h04;
`ifdef APB_TIMEOUT_EN
    begin
      int k;
      bit found;
      k = 0; found = 1'b0;
      sb.push_back('{2'b01, 32'h0, 1'b1});
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      for (int c = 1; c <= 40 && !found; c++) begin
        if (rsp_done != 2'b00) begin
          found = 1'b1; k = c;
        end else begin
          @(posedge pclk); #1;
        end
      end
      check("tmo_cycles", 64'(k), 64'd16);
      check("tmo_err", 64'(rsp_err), 64'd1);
      req_valid = 2'b00;
      @(posedge pclk); #1;
      check("tmo_idle", 64'({psel, penable, busy}), 64'd0);
    end
`else
    sb.push_back('{2'b01, 32'hA5A5A5A5, 1'b0});
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    repeat (100) @(posedge pclk);
    #1;
    check("stall_psel_pen", 64'({psel, penable}), 64'(2'b11));
    check("stall_no_done", 64'(rsp_done), 64'd0);
    pready = 1'b1;
    #1;
    check("stall_done", 64'(rsp_done), 64'(2'b01));
    @(posedge pclk); #1;
    pready = 1'b0; req_valid = 2'b00;
`endif

    // Reset asserted in the middle of an ACCESS phase
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[63:32] = 32'h40; req_wdata[63:32] = 32'h11112222;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check("mid_access", 64'({psel, penable}), 64'(2'b11));
    #2;
    preset = 1'b1;
    #1;
    check("mid_rst_ctrl", 64'({psel, penable, busy, pwrite}), 64'd0);
    check("mid_rst_done", 64'(rsp_done), 64'd0);
    check("mid_rst_paddr", 64'(paddr), 64'd0);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    preset = 1'b0;
    @(posedge pclk); #1;
    check("mid_rst_idle", 64'({psel, busy, rsp_done}), 64'd0);

    // Round robin: both requesting, four transfers each
    req_write = 2'b00;
    req_addr[31:0] = 32'h04; req_addr[63:32] = 32'h08;
    req_valid = 2'b11; pready = 1'b1;
    for (int n = 0; n < 8; n++)
      sb.push_back((n % 2 == 0) ? '{2'b01, 32'hA5A5A5A5, 1'b0} : '{2'b10, 32'h12345678, 1'b0});
    begin
      int cnt0, cnt1, prev;
      cnt0 = 0; cnt1 = 0; prev = -1;
      for (int n = 0; n < 8; n++) begin
        int c, g;
        bit found;
        c = 0; found = 1'b0;
        while (!found && c < 10) begin
          @(posedge pclk); #1;
          c++;
          if (rsp_done != 2'b00) found = 1'b1;
        end
        check("rr_latency", 64'(c), (n == 0) ? 64'd2 : 64'd3);
        g = rsp_done[1] ? 1 : 0;
        check("rr_grant", 64'(g), 64'(n % 2));
        check("rr_no_repeat", 64'(g == prev), 64'd0);
        prev = g;
        if (g == 0) cnt0++; else cnt1++;
        if (cnt0 == 4) req_valid[0] = 1'b0;
        if (cnt1 == 4) req_valid[1] = 1'b0;
      end
    end
    @(posedge pclk); #1;
    pready = 1'b0;
    check("rr_idle", 64'({psel, busy}), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
